eth_10g_mon_run_ctrl: RTL and testbench

//  Avalon-MM master that sequences one receive-test run on the 10G packet monitor (eth_10g_mon).
//  On go: programs the packet count, issues a start pulse and polls for done (or timeout/abort).

---
 rtl/eth_10g_mon_pkg.sv | 39 +++
 rtl/eth_10g_mon_wdog.sv | 31 +++
 rtl/eth_10g_mon_run_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_eth_10g_mon_run_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_10g_mon_pkg.sv
// Register map, control bits and run-sequencer state encoding
// shared by the 10G packet monitor and its run controller.
package eth_10g_mon_pkg;

  localparam logic [2:0] ADDR_NUM     = 3'd0;
  localparam logic [2:0] ADDR_OK      = 3'd1;
  localparam logic [2:0] ADDR_ERR     = 3'd2;
  localparam logic [2:0] ADDR_BYTE_LO = 3'd3;
  localparam logic [2:0] ADDR_BYTE_HI = 3'd4;
  localparam logic [2:0] ADDR_CYC_LO  = 3'd5;
  localparam logic [2:0] ADDR_CYC_HI  = 3'd6;
  localparam logic [2:0] ADDR_CTRL    = 3'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_DONE  = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_NUM,
    S_WR_GO,
    S_WR_REL,
    S_WAIT,
    S_POLL,
    S_WR_STOP,
    S_RD1,
    S_RD2,
    S_RD3,
    S_RD4,
    S_RD5,
    S_RD6,
    S_FIN
  } run_state_t;

  function automatic logic [31:0] ctrl_word(input int b);
    return 32'(1) << b;
  endfunction

endpackage

// File: rtl/eth_10g_mon_wdog.sv
// Loadable saturating watchdog: clr reloads limit and zeroes count.
// Ports: clk, reset_n, i_clr, i_en, i_limit -> o_expired (limit 0 = never).
module eth_10g_mon_wdog #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_lim;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_lim <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_lim <= i_limit;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = (r_lim != '0) && (r_cnt == r_lim);

endmodule

// File: rtl/eth_10g_mon_run_ctrl.sv
// Avalon-MM master sequencing one receive-test run on eth_10g_mon.
// Ports: go/abort/cfg in; mon_* bus; busy/done/pass/flags/counters out.
module eth_10g_mon_run_ctrl
  import eth_10g_mon_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int TMO_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             abort,
  input  logic [31:0]      num_packets,
  input  logic [TMO_W-1:0] timeout_cycles,
  output logic [2:0]       mon_address,
  output logic             mon_write,
  output logic             mon_read,
  output logic [31:0]      mon_writedata,
  input  logic [31:0]      mon_readdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic             aborted,
  output logic [31:0]      ok_count,
  output logic [31:0]      err_count,
  output logic [63:0]      byte_count,
  output logic [63:0]      cycle_count
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  run_state_t r_state;
  run_state_t w_next;

  logic [GAP_W-1:0] r_gap;
  logic [31:0]      r_num;
  logic             r_pass;
  logic             r_to;
  logic             r_ab;
  logic [31:0]      r_ok;
  logic [31:0]      r_err;
  logic [63:0]      r_byte;
  logic [63:0]      r_cyc;

  logic        w_start;
  logic        w_exp;
  logic        w_wd_en;
  logic        w_ab_win;
  logic        w_set_to;
  logic        w_set_ab;
  logic        w_pass;
  logic [2:0]  w_addr;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_wdata;

  assign w_start  = (r_state == S_IDLE) && go;
  assign w_wd_en  = (r_state == S_WAIT) || (r_state == S_POLL);
  assign w_ab_win = (r_state >= S_WR_NUM) && (r_state <= S_POLL);

  eth_10g_mon_wdog #(
    .W(TMO_W)
  ) u_wdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_start),
    .i_en     (w_wd_en),
    .i_limit  (timeout_cycles),
    .o_expired(w_exp)
  );

  always_comb begin
    w_next   = r_state;
    w_addr   = '0;
    w_wr     = 1'b0;
    w_rd     = 1'b0;
    w_wdata  = '0;
    w_set_to = 1'b0;
    w_set_ab = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (go) w_next = S_WR_NUM;
      end
      S_WR_NUM: begin
        w_wr    = 1'b1;
        w_addr  = ADDR_NUM;
        w_wdata = r_num;
        w_next  = S_WR_GO;
      end
      S_WR_GO: begin
        w_wr    = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = ctrl_word(CTRL_START);
        w_next  = S_WR_REL;
      end
      S_WR_REL: begin
        w_wr   = 1'b1;
        w_addr = ADDR_CTRL;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_exp) begin
          w_set_to = 1'b1;
          w_next   = S_WR_STOP;
        end else if (r_gap == GAP_LAST) begin
          w_next = S_POLL;
        end
      end
      S_POLL: begin
        w_rd   = 1'b1;
        w_addr = ADDR_CTRL;
        // a completed run beats a watchdog hit in the same cycle
        if (mon_readdata[CTRL_DONE]) begin
          w_next = S_WR_STOP;
        end else if (w_exp) begin
          w_set_to = 1'b1;
          w_next   = S_WR_STOP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WR_STOP: begin
        w_wr    = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = ctrl_word(CTRL_STOP);
        w_next  = S_RD1;
      end
      S_RD1: begin
        w_rd = 1'b1; w_addr = ADDR_OK;      w_next = S_RD2;
      end
      S_RD2: begin
        w_rd = 1'b1; w_addr = ADDR_ERR;     w_next = S_RD3;
      end
      S_RD3: begin
        w_rd = 1'b1; w_addr = ADDR_BYTE_LO; w_next = S_RD4;
      end
      S_RD4: begin
        w_rd = 1'b1; w_addr = ADDR_BYTE_HI; w_next = S_RD5;
      end
      S_RD5: begin
        w_rd = 1'b1; w_addr = ADDR_CYC_LO;  w_next = S_RD6;
      end
      S_RD6: begin
        w_rd = 1'b1; w_addr = ADDR_CYC_HI;  w_next = S_FIN;
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // abort overrides the normal successor; the current access still issues
    if (w_ab_win && abort) begin
      w_set_ab = 1'b1;
      w_next   = S_WR_STOP;
    end
  end

  // flags and ok/err are final by RD6, so pass is ready alongside done
  assign w_pass = ~r_to & ~r_ab & (r_err == '0) & (r_ok == r_num);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_num   <= '0;
      r_pass  <= 1'b0;
      r_to    <= 1'b0;
      r_ab    <= 1'b0;
      r_ok    <= '0;
      r_err   <= '0;
      r_byte  <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_next;
      r_gap   <= (r_state == S_WAIT) ? r_gap + GAP_W'(1) : '0;
      if (w_start) begin
        r_num  <= num_packets;
        r_pass <= 1'b0;
        r_to   <= 1'b0;
        r_ab   <= 1'b0;
      end
      if (w_set_to) r_to <= 1'b1;
      if (w_set_ab) r_ab <= 1'b1;
      if (r_state == S_RD1) r_ok          <= mon_readdata;
      if (r_state == S_RD2) r_err         <= mon_readdata;
      if (r_state == S_RD3) r_byte[31:0]  <= mon_readdata;
      if (r_state == S_RD4) r_byte[63:32] <= mon_readdata;
      if (r_state == S_RD5) r_cyc[31:0]   <= mon_readdata;
      if (r_state == S_RD6) r_cyc[63:32]  <= mon_readdata;
      if (r_state == S_RD6) r_pass        <= w_pass;
    end
  end

  assign mon_address   = w_addr;
  assign mon_write     = w_wr;
  assign mon_read      = w_rd;
  assign mon_writedata = w_wdata;
  assign busy          = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done          = (r_state == S_FIN);
  assign pass          = r_pass;
  assign timed_out     = r_to;
  assign aborted       = r_ab;
  assign ok_count      = r_ok;
  assign err_count     = r_err;
  assign byte_count    = r_byte;
  assign cycle_count   = r_cyc;

endmodule

// File: tb/tb_eth_10g_mon_run_ctrl.sv
// Directed bench for eth_10g_mon_run_ctrl with a register-level
// monitor model; logs every bus access for order checks.
module tb_eth_10g_mon_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic        abort;
  logic [31:0] num_packets;
  logic [31:0] timeout_cycles;
  logic [2:0]  mon_address;
  logic        mon_write;
  logic        mon_read;
  logic [31:0] mon_writedata;
  logic [31:0] mon_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timed_out;
  logic        aborted;
  logic [31:0] ok_count;
  logic [31:0] err_count;
  logic [63:0] byte_count;
  logic [63:0] cycle_count;

  logic [31:0] mreg [8];
  logic        tb_done;

  int checks = 0;
  int errors = 0;
  int dones = 0;
  int collide = 0;
  logic [34:0] wlog [$];
  logic [2:0]  rlog [$];

  always #5 clk = ~clk;

  eth_10g_mon_run_ctrl #(
    .POLL_GAP(4),
    .TMO_W   (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .abort         (abort),
    .num_packets   (num_packets),
    .timeout_cycles(timeout_cycles),
    .mon_address   (mon_address),
    .mon_write     (mon_write),
    .mon_read      (mon_read),
    .mon_writedata (mon_writedata),
    .mon_readdata  (mon_readdata),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timed_out     (timed_out),
    .aborted       (aborted),
    .ok_count      (ok_count),
    .err_count     (err_count),
    .byte_count    (byte_count),
    .cycle_count   (cycle_count)
  );

  assign mon_readdata = (mon_address == 3'd7) ?
                        {29'd0, tb_done, 2'b00} : mreg[mon_address];

  always @(posedge clk) begin
    if (mon_write) wlog.push_back({mon_address, mon_writedata});
    if (mon_read) rlog.push_back(mon_address);
    if (done) dones++;
    if (mon_write && mon_read) collide++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    wlog.delete();
    rlog.delete();
    dones = 0;
  endtask

  task automatic run_go(input logic [31:0] n, input logic [31:0] t);
    num_packets    = n;
    timeout_cycles = t;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic wait_rd(input string tag, input logic [2:0] a);
    int k = 0;
    while (!(mon_read && mon_address == a) && k < 100) begin
      tick();
      k++;
    end
    chk({tag, "_rd_seen"}, 64'(mon_read), 64'd1);
  endtask

  initial begin
    int n0;
    reset_n = 1'b0;
    go = 1'b0;
    abort = 1'b0;
    num_packets = '0;
    timeout_cycles = '0;
    tb_done = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_strobes", 64'({mon_write, mon_read}), 64'd0);
    chk("rst_ok", 64'(ok_count), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: clean 100-frame run, latency and bus order
    mreg[1] = 32'd100; mreg[2] = 32'd0;
    mreg[3] = 32'd6400; mreg[4] = 32'd0;
    mreg[5] = 32'h1234; mreg[6] = 32'd1;
    tb_done = 1'b1;
    clr_logs();
    run_go(32'd100, 32'd0);
    chk("t1_lat_wr", 64'(mon_write), 64'd1);
    chk("t1_lat_addr", 64'(mon_address), 64'd0);
    chk("t1_lat_data", 64'(mon_writedata), 64'd100);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1");
    chk("t1_ok", 64'(ok_count), 64'd100);
    chk("t1_err", 64'(err_count), 64'd0);
    chk("t1_bytes", byte_count, 64'd6400);
    chk("t1_cycles", cycle_count, 64'h1_0000_1234);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_busy_fin", 64'(busy), 64'd0);
    tick();
    tick();
    chk("t1_done_once", 64'(dones), 64'd1);
    chk("t1_nwr", 64'(wlog.size()), 64'd4);
    chk("t1_stop", 64'(wlog[3]), {29'd0, 3'd7, 32'd2});
    chk("t1_nrd", 64'(rlog.size()), 64'd7);
    chk("t1_rd6", 64'(rlog[6]), 64'd6);

    // 2: CRC errors; watchdog hits on the same POLL as done
    mreg[1] = 32'd8; mreg[2] = 32'd2;
    tb_done = 1'b1;
    run_go(32'd10, 32'd4);
    wait_done("t2");
    chk("t2_ok", 64'(ok_count), 64'd8);
    chk("t2_err", 64'(err_count), 64'd2);
    chk("t2_pass", 64'(pass), 64'd0);
    chk("t2_tmo", 64'(timed_out), 64'd0);
    tick();
    tick();

    // 3: watchdog expiry after four unsuccessful polls
    mreg[1] = 32'd20; mreg[2] = 32'd0;
    tb_done = 1'b0;
    clr_logs();
    run_go(32'd50, 32'd20);
    wait_done("t3");
    chk("t3_tmo", 64'(timed_out), 64'd1);
    chk("t3_abort", 64'(aborted), 64'd0);
    chk("t3_ok", 64'(ok_count), 64'd20);
    chk("t3_pass", 64'(pass), 64'd0);
    chk("t3_nrd", 64'(rlog.size()), 64'd10);
    chk("t3_rd_first", 64'(rlog[4]), 64'd1);
    chk("t3_rd_last", 64'(rlog[9]), 64'd6);
    tick();
    tick();

    // 4: abort in POLL, plus a go while busy
    mreg[1] = 32'd5; mreg[2] = 32'd0;
    tb_done = 1'b0;
    clr_logs();
    run_go(32'd5, 32'd0);
    repeat (4) tick();
    num_packets = 32'd77;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("t4_busy", 64'(busy), 64'd1);
    wait_rd("t4_poll", 3'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_stop_wr", 64'(mon_write), 64'd1);
    chk("t4_stop_addr", 64'(mon_address), 64'd7);
    chk("t4_stop_data", 64'(mon_writedata), 64'd2);
    wait_done("t4");
    chk("t4_aborted", 64'(aborted), 64'd1);
    chk("t4_tmo", 64'(timed_out), 64'd0);
    chk("t4_pass", 64'(pass), 64'd0);
    tick();
    tick();
    chk("t4_idle", 64'(busy), 64'd0);
    n0 = 0;
    foreach (wlog[i]) if (wlog[i][34:32] == 3'd0) n0++;
    chk("t4_one_num_wr", 64'(n0), 64'd1);

    // 5: zero packets, start sequence order
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    tb_done = 1'b1;
    clr_logs();
    run_go(32'd0, 32'd0);
    wait_done("t5");
    chk("t5_pass", 64'(pass), 64'd1);
    chk("t5_aborted", 64'(aborted), 64'd0);
    chk("t5_w0", 64'(wlog[0]), {29'd0, 3'd0, 32'd0});
    chk("t5_w1", 64'(wlog[1]), {29'd0, 3'd7, 32'd1});
    chk("t5_w2", 64'(wlog[2]), {29'd0, 3'd7, 32'd0});
    tick();
    tick();

    // 6: reset during RD3, then a clean rerun
    mreg[1] = 32'd3; mreg[3] = 32'd192;
    tb_done = 1'b1;
    run_go(32'd3, 32'd0);
    wait_rd("t6_rd3", 3'd3);
    reset_n = 1'b0;
    tick();
    chk("t6_strobes", 64'({mon_write, mon_read}), 64'd0);
    chk("t6_ok", 64'(ok_count), 64'd0);
    chk("t6_bytes", byte_count, 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_pass", 64'(pass), 64'd0);
    reset_n = 1'b1;
    tick();
    clr_logs();
    run_go(32'd3, 32'd0);
    wait_done("t6b");
    chk("t6b_pass", 64'(pass), 64'd1);
    chk("t6b_ok", 64'(ok_count), 64'd3);
    chk("t6b_bytes", byte_count, 64'd192);
    chk("t6b_nwr", 64'(wlog.size()), 64'd4);
    tick();

    chk("no_rd_wr_overlap", 64'(collide), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
